vfifo_sc_fifo: RTL
==================

# vfifo_sc_fifo

Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides. Wraps the team's dual-port RAM (port A write-only, port B read-only, 1-cycle registered read) and adds pointer control, occupancy tracking and a prefetch/skid output stage so the read side sustains one word per cycle. Sits between any streaming producer and consumer in the same clock domain. It is the standard front end for all RAM-backed buffering in the FIFO library.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 8, RAM address width; capacity DEPTH = 2^ADDR_WIDTH words
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush, active-high
- wr_data  in  DATA_WIDTH  write word
- wr_valid  in  1  producer has a word
- wr_ready  out  1  FIFO accepts a word this cycle
- rd_data  out  DATA_WIDTH  head word, valid when rd_valid
- rd_valid  out  1  head word present
- rd_ready  in  1  consumer takes head this cycle
- fill_count  out  ADDR_WIDTH+1  words held (RAM + in-flight + output stage)

## Operation
- Write accepted when wr_valid & wr_ready; the word goes to RAM port A at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read accepted when rd_valid & rd_ready; the head is dropped from the output stage.
- ram_count counts words in RAM not yet fetched. A port-B fetch at rd_ptr is issued when ram_count > 0 and the output stage, after this cycle's accepted read, has a free slot for the returning word. On issue, rd_ptr increments and ram_count decrements.
- Output stage holds at most 2 words: the RAM output (q_b) stage and one holding register. rd_data comes from the older of the two. Order is strictly preserved.
- A fetch never targets the slot written in the same cycle: ram_count excludes the current write. The RAM's read-during-write behaviour is therefore irrelevant.
- fill_count: +1 on write only, -1 on read only, unchanged on both or neither.
- wr_ready = (fill_count != DEPTH), registered. Total capacity is exactly DEPTH.
- clear: next cycle, both pointers, ram_count and fill_count are 0, output-stage valids are cleared, and an in-flight fetch is discarded. A write or read presented in the clear cycle is ignored. wr_ready = 1 and rd_valid = 0 the cycle after.
- Reset values: rd_valid 0, rd_data 0, fill_count 0, wr_ready 1 (held 1 while rst is asserted), pointers 0.

## Timing
- Latency into an empty FIFO: write accepted at edge N, fetch issued in cycle N→N+1, rd_valid high after edge N+2.
- Throughput: one write and one read per cycle sustained. No bubble on rd_valid while fill_count ≥ 2 and rd_ready is held high.
- Full: at fill_count = DEPTH, wr_ready is low. A simultaneous read at full does not raise wr_ready until the next cycle.
- Empty: rd_valid low, rd_data holds its last value, and rd_ready is ignored.
- Pointer wrap from DEPTH-1 to 0 is transparent. Full and empty are derived from fill_count, never from pointer equality.
- rst asserted mid-transfer: all state returns to reset values immediately. Contents are lost, and RAM data is not cleared.
- Handshake: rd_data and rd_valid are stable while rd_valid & !rd_ready. wr_ready does not depend combinationally on wr_valid.

## Structure
- Shared package vfifo_pkg holds DEPTH derivation (1 << ADDR_WIDTH) and the fill_count width constant ADDR_WIDTH+1. These are reused by the async and sync FIFO variants.
- One sub-module instance: vfifo_dual_port_ram_sc_dw with we_b tied 0 and d_b tied 0. q_a is unused.
- Control, occupancy and output stage live in this module. No further sub-modules.

## Test plan
All scenarios use ADDR_WIDTH=2 (DEPTH=4) and DATA_WIDTH=8.
- Fill then drain: write 0x11,0x22,0x33,0x44 back-to-back with rd_ready=0 → wr_ready low after the 4th, fill_count=4. Then rd_ready=1 → reads 0x11..0x44 on 4 consecutive cycles, fill_count returns to 0, rd_valid drops.
- First-word latency: write 0xA5 at edge N into an empty FIFO → rd_valid=1, rd_data=0xA5 after edge N+2.
- Streaming and wrap: 20 words 0x00..0x13 with wr_valid=rd_ready=1 continuously → output in order, no rd_valid gaps after the first word, pointers wrap 5 times.
- Backpressure: at fill_count=2, toggle rd_ready 1,0,1,0 → rd_data stable during each stall, no loss or duplication.
- Simultaneous at full: at fill_count=4, assert wr_valid and rd_ready → read accepted, write refused, fill_count=3, wr_ready=1 the next cycle.
- Clear and reset: with fill_count=3 and a fetch in flight, pulse clear → fill_count=0 and rd_valid=0 next cycle, and a subsequent write of 0x5A is the next word read. Repeat with rst asserted asynchronously → same reset values.

Source files
------------

// File: rtl/vfifo_pkg.sv
// Shared sizing helpers for the FIFO library (sync and async variants).
// Capacity and occupancy-counter width are both derived from the RAM address width.
package vfifo_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Occupancy counters must represent DEPTH itself, hence one extra bit.
    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/vfifo_dual_port_ram_sc_dw.sv
// Single-clock dual-port RAM, both ports read/write, 1-cycle registered read (old data on collision).
module vfifo_dual_port_ram_sc_dw #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] d_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] d_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem_q[addr_a] <= d_a;
        if (we_b) mem_q[addr_b] <= d_b;
        q_a <= mem_q[addr_a];
        q_b <= mem_q[addr_b];
    end

endmodule

// File: rtl/vfifo_sc_fifo.sv
// Single-clock FWFT FIFO: RAM-backed storage with a two-slot prefetch/skid output stage
// so the read side sustains one word per cycle.
module vfifo_sc_fifo
    import vfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic [count_width(ADDR_WIDTH)-1:0]   fill_count
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
    localparam int unsigned CW    = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ram_count_q, ram_count_d, fill_q, fill_d;
    logic                  wr_ready_q;
    logic                  fetch_q;
    logic                  head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
    logic                  wr_accept, rd_accept, fetch;
    logic [1:0]            stage_occ;
    logic [DATA_WIDTH-1:0] ram_q_b, ram_q_a_unused;

    assign wr_accept = wr_valid & wr_ready_q & ~clear;
    assign rd_accept = head_valid_q & rd_ready & ~clear;

    // Slots claimed next cycle: head + skid + word returning on q_b, minus this cycle's pop.
    assign stage_occ = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(fetch_q) - 2'(rd_accept);
    assign fetch     = (ram_count_q != '0) && (stage_occ < 2'd2);

    always_comb begin
        wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(wr_accept);
        rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(fetch);
        ram_count_d  = ram_count_q + CW'(wr_accept) - CW'(fetch);
        fill_d       = fill_q + CW'(wr_accept) - CW'(rd_accept);
        head_valid_d = head_valid_q;
        head_d       = head_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (rd_accept || !head_valid_q) begin
            if (skid_valid_q) begin
                head_valid_d = 1'b1;
                head_d       = skid_q;
                skid_valid_d = fetch_q;
                skid_d       = ram_q_b;
            end else if (fetch_q) begin
                head_valid_d = 1'b1;
                head_d       = ram_q_b;
                skid_valid_d = 1'b0;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (fetch_q) begin
            skid_valid_d = 1'b1;
            skid_d       = ram_q_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            fill_q       <= '0;
            wr_ready_q   <= 1'b1;
            fetch_q      <= 1'b0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
        end else if (clear) begin
            // Dropping fetch_q discards any word still on its way out of the RAM.
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            fill_q       <= '0;
            wr_ready_q   <= 1'b1;
            fetch_q      <= 1'b0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            fill_q       <= fill_d;
            wr_ready_q   <= (fill_d != FULL_COUNT);
            fetch_q      <= fetch;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign rd_valid   = head_valid_q;
    assign rd_data    = head_q;
    assign fill_count = fill_q;

    vfifo_dual_port_ram_sc_dw #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we_a  (wr_accept),
        .addr_a(wr_ptr_q),
        .d_a   (wr_data),
        .q_a   (ram_q_a_unused),
        .we_b  (1'b0),
        .addr_b(rd_ptr_q),
        .d_b   ('0),
        .q_b   (ram_q_b)
    );

endmodule
